wb_stage_mc: RTL

- Parametrised writeback stage for the RV pipeline, successor to the single-cycle combinational writeback mux.
- Adds a 4-way writeback source select (ALU, load, PC+4, CSR) and load byte/half extraction with sign/zero extension.
- Adds a valid/ready handshake toward MEM/WB, so loads whose data returns late (multi-cycle data memory) stall the stage.
- Register-file write port is registered: one-cycle latency from completion to the write outputs.

---
 rtl/wb_stage_mc.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/wb_stage_mc.sv
// wb_stage_mc: multi-cycle writeback stage.
// Selects the writeback source (ALU, load, PC+4, CSR) and extracts and extends load bytes/halves/words.
// A load whose data is not yet back parks the stage in WAIT_MEM, which stalls MEM/WB through in_ready.
// The register-file write port is registered, so a write appears one cycle after completion.
// Optional feature: define WB_INSTRET_EN to count retired instructions on instret_out.
//
// state    | meaning
// IDLE     | ready to accept; non-loads and same-cycle loads complete here
// WAIT_MEM | accepted load is waiting for mem_rsp_valid; in_ready is low
module wb_stage_mc #(
    parameter int XLEN      = 32,
    parameter int RA_W      = 5,
    parameter int OFS_W     = 2,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc_4,
    input  logic [XLEN-1:0]      in_alu_result,
    input  logic [XLEN-1:0]      in_csr_rdata,
    input  logic [RA_W-1:0]      in_rd,
    input  logic                 in_reg_write_en,
    input  logic [1:0]           in_wb_sel,
    input  logic [2:0]           in_funct3,
    input  logic [OFS_W-1:0]     in_byte_ofs,
    input  logic                 mem_rsp_valid,
    input  logic [XLEN-1:0]      mem_rsp_data,
    output logic                 reg_write_en_out,
    output logic [RA_W-1:0]      reg_write_addr_out,
    output logic [XLEN-1:0]      reg_write_data_out,
    output logic [INSTRET_W-1:0] instret_out
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    state_t           state;
    logic [RA_W-1:0]  p_rd;
    logic             p_we;
    logic [2:0]       p_funct3;
    logic [OFS_W-1:0] p_ofs;

    logic             accept;
    logic             done;
    logic [RA_W-1:0]  c_rd;
    logic             c_we;
    logic [2:0]       ld_f3;
    logic [OFS_W-1:0] ld_ofs;
    logic [OFS_W+2:0] byte_sh;
    logic [OFS_W+2:0] half_sh;
    logic [OFS_W+2:0] word_sh;
    logic [XLEN-1:0]  lane_b;
    logic [XLEN-1:0]  lane_h;
    logic [XLEN-1:0]  lane_w;
    logic [XLEN-1:0]  ld_data;
    logic [XLEN-1:0]  c_data;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // Completion decode: which instruction finishes this cycle and with what rd/enable.
    always_comb begin
        done = 1'b0;
        c_rd = in_rd;
        c_we = in_reg_write_en;
        if (state == IDLE) begin
            done = accept && ((in_wb_sel != SEL_LOAD) || mem_rsp_valid);
        end else begin
            done = mem_rsp_valid;
            c_rd = p_rd;
            c_we = p_we;
        end
    end

    // Load extraction; a pending load uses its captured size code and offset.
    always_comb begin
        ld_f3   = (state == WAIT_MEM) ? p_funct3 : in_funct3;
        ld_ofs  = (state == WAIT_MEM) ? p_ofs : in_byte_ofs;
        byte_sh = {ld_ofs, 3'b000};
        half_sh = {ld_ofs[OFS_W-1:1], 4'b0000};
        word_sh = '0;
        if (XLEN == 64) word_sh = {ld_ofs[OFS_W-1], {(OFS_W+2){1'b0}}};
        lane_b  = mem_rsp_data >> byte_sh;
        lane_h  = mem_rsp_data >> half_sh;
        lane_w  = mem_rsp_data >> word_sh;
        ld_data = '0;
        case (ld_f3)
            3'b000:  ld_data = XLEN'($signed(lane_b[7:0]));
            3'b001:  ld_data = XLEN'($signed(lane_h[15:0]));
            3'b010:  ld_data = XLEN'($signed(lane_w[31:0]));
            3'b100:  ld_data = XLEN'(lane_b[7:0]);
            3'b101:  ld_data = XLEN'(lane_h[15:0]);
            3'b110:  if (XLEN == 64) ld_data = XLEN'(lane_w[31:0]);
            3'b011:  if (XLEN == 64) ld_data = mem_rsp_data;
            default: ld_data = '0;
        endcase
    end

    // Writeback source select.
    always_comb begin
        c_data = ld_data;
        if (state == IDLE) begin
            case (in_wb_sel)
                SEL_ALU:  c_data = in_alu_result;
                SEL_LOAD: c_data = ld_data;
                SEL_PC4:  c_data = in_pc_4;
                default:  c_data = in_csr_rdata;
            endcase
        end
    end

    // FSM plus registered write port; rd=0 completions drive zero address and data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            p_rd               <= '0;
            p_we               <= 1'b0;
            p_funct3           <= '0;
            p_ofs              <= '0;
            reg_write_en_out   <= 1'b0;
            reg_write_addr_out <= '0;
            reg_write_data_out <= '0;
        end else begin
            reg_write_en_out <= 1'b0;
            if (done) begin
                reg_write_en_out   <= c_we && (c_rd != '0);
                reg_write_addr_out <= c_rd;
                reg_write_data_out <= (c_rd != '0) ? c_data : '0;
            end
            case (state)
                IDLE: begin
                    if (accept && (in_wb_sel == SEL_LOAD) && !mem_rsp_valid) begin
                        state    <= WAIT_MEM;
                        p_rd     <= in_rd;
                        p_we     <= in_reg_write_en;
                        p_funct3 <= in_funct3;
                        p_ofs    <= in_byte_ofs;
                    end
                end
                default: begin
                    if (mem_rsp_valid) state <= IDLE;
                end
            endcase
        end
    end

`ifdef WB_INSTRET_EN
    logic [INSTRET_W-1:0] instret_q;

    // Retire counter advances on the same edge as the write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) instret_q <= '0;
        else if (done) instret_q <= instret_q + 1'b1;
    end

    assign instret_out = instret_q;
`else
    assign instret_out = '0;
`endif

endmodule
